// File: rtl/hazard_ctrl.sv
// Central hazard controller for the five-stage core: stall/flush generation,
// E-stage operand forwarding and multi-cycle divider sequencing.
module hazard_ctrl #(
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned RA_W       = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RA_W-1:0] rs_d,
    input  logic [RA_W-1:0] rt_d,
    input  logic [RA_W-1:0] rs_e,
    input  logic [RA_W-1:0] rt_e,
    input  logic [RA_W-1:0] wreg_e,
    input  logic [RA_W-1:0] wreg_m,
    input  logic [RA_W-1:0] wreg_w,
    input  logic            regwrite_e,
    input  logic            regwrite_m,
    input  logic            regwrite_w,
    input  logic            memtoreg_e,
    input  logic            redirect_e,
    input  logic            div_start_e,
    input  logic            mem_req_m,
    input  logic            mem_ready_m,
    output logic            stall_f,
    output logic            stall_d,
    output logic            stall_e,
    output logic            stall_m,
    output logic            flush_d,
    output logic            flush_e,
    output logic            flush_m,
    output logic            flush_w,
    output logic [1:0]      fwd_a_e,
    output logic [1:0]      fwd_b_e,
    output logic            div_busy,
    output logic            div_done
);

    localparam int unsigned CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } div_state_t;

    div_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    logic mem_stall;
    logic div_stall;
    logic load_use;

    assign mem_stall = mem_req_m && !mem_ready_m;
    assign div_stall = (state == IDLE && div_start_e) || state == BUSY;
    assign load_use  = memtoreg_e && regwrite_e && (wreg_e != '0)
                       && ((wreg_e == rs_d) || (wreg_e == rt_d));

    // M-stage result is newer than W, so it wins when both match.
    function automatic logic [1:0] fwd_sel(
        input logic [RA_W-1:0] src,
        input logic            wr_m,
        input logic [RA_W-1:0] dst_m,
        input logic            wr_w,
        input logic [RA_W-1:0] dst_w
    );
        if (wr_m && (dst_m != '0) && (dst_m == src))
            return 2'b10;
        else if (wr_w && (dst_w != '0) && (dst_w == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (div_start_e && !mem_stall) begin
                    state_n = BUSY;
                    cnt_n   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt == '0)
                    state_n = DONE;
                else
                    cnt_n = cnt - CNT_W'(1);
            end
            DONE: begin
                if (!mem_stall)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // A redirect masked by a stall is simply re-evaluated next cycle, since
    // the branch is held in E until nothing above it is active.
    always_comb begin
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        stall_e  = 1'b0;
        stall_m  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        flush_m  = 1'b0;
        flush_w  = 1'b0;
        fwd_a_e  = 2'b00;
        fwd_b_e  = 2'b00;
        div_busy = 1'b0;
        div_done = 1'b0;
        if (!rst) begin
            if (mem_stall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else if (div_stall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                flush_m = 1'b1;
            end else if (redirect_e) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (load_use) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
            fwd_a_e  = fwd_sel(rs_e, regwrite_m, wreg_m, regwrite_w, wreg_w);
            fwd_b_e  = fwd_sel(rt_e, regwrite_m, wreg_m, regwrite_w, wreg_w);
            div_busy = div_stall;
            div_done = (state == DONE);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with a 4-cycle divider.
module tb_hazard_ctrl;

    localparam int unsigned RA_W = 5;

    // {stall_f,stall_d,stall_e,stall_m, flush_d,flush_e,flush_m,flush_w, div_busy,div_done}
    localparam logic [9:0] C_NONE     = 10'b0000_0000_00;
    localparam logic [9:0] C_MEM      = 10'b1111_0001_00;
    localparam logic [9:0] C_MEM_BUSY = 10'b1111_0001_10;
    localparam logic [9:0] C_MEM_DONE = 10'b1111_0001_01;
    localparam logic [9:0] C_DIV      = 10'b1110_0010_10;
    localparam logic [9:0] C_DONE     = 10'b0000_0000_01;
    localparam logic [9:0] C_RED      = 10'b0000_1100_00;
    localparam logic [9:0] C_LU       = 10'b1100_0100_00;

    logic            clk = 1'b0;
    logic            rst;
    logic [RA_W-1:0] rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w;
    logic            regwrite_e, regwrite_m, regwrite_w, memtoreg_e;
    logic            redirect_e, div_start_e, mem_req_m, mem_ready_m;
    logic            stall_f, stall_d, stall_e, stall_m;
    logic            flush_d, flush_e, flush_m, flush_w;
    logic [1:0]      fwd_a_e, fwd_b_e;
    logic            div_busy, div_done;
    logic [9:0]      ctl;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    assign ctl = {stall_f, stall_d, stall_e, stall_m,
                  flush_d, flush_e, flush_m, flush_w, div_busy, div_done};

    hazard_ctrl #(
        .DIV_CYCLES(4),
        .RA_W      (RA_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rs_d       (rs_d),
        .rt_d       (rt_d),
        .rs_e       (rs_e),
        .rt_e       (rt_e),
        .wreg_e     (wreg_e),
        .wreg_m     (wreg_m),
        .wreg_w     (wreg_w),
        .regwrite_e (regwrite_e),
        .regwrite_m (regwrite_m),
        .regwrite_w (regwrite_w),
        .memtoreg_e (memtoreg_e),
        .redirect_e (redirect_e),
        .div_start_e(div_start_e),
        .mem_req_m  (mem_req_m),
        .mem_ready_m(mem_ready_m),
        .stall_f    (stall_f),
        .stall_d    (stall_d),
        .stall_e    (stall_e),
        .stall_m    (stall_m),
        .flush_d    (flush_d),
        .flush_e    (flush_e),
        .flush_m    (flush_m),
        .flush_w    (flush_w),
        .fwd_a_e    (fwd_a_e),
        .fwd_b_e    (fwd_b_e),
        .div_busy   (div_busy),
        .div_done   (div_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0;
        wreg_e = '0; wreg_m = '0; wreg_w = '0;
        regwrite_e = 1'b0; regwrite_m = 1'b0; regwrite_w = 1'b0;
        memtoreg_e = 1'b0; redirect_e = 1'b0; div_start_e = 1'b0;
        mem_req_m = 1'b0; mem_ready_m = 1'b0;
    endtask

    // Settle, check the control vector, then advance one clock.
    task automatic cyc(input string tag, input logic [9:0] exp);
        #1;
        check(tag, 32'(ctl), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        mem_req_m = 1'b1; redirect_e = 1'b1; div_start_e = 1'b1;
        regwrite_m = 1'b1; wreg_m = 5'd3; rs_e = 5'd3; rt_e = 5'd3;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_ctl", 32'(ctl), 32'(C_NONE));
        check("rst_fwd", 32'({fwd_a_e, fwd_b_e}), 32'(4'b0000));
        rst = 1'b0;
        clear_inputs();

        // Forwarding: add r3 in M, sub r4,r3,r3 in E; W also writes r3
        regwrite_m = 1'b1; wreg_m = 5'd3; regwrite_w = 1'b1; wreg_w = 5'd3;
        rs_e = 5'd3; rt_e = 5'd3;
        #1;
        check("fwd_m_a", 32'(fwd_a_e), 32'(2'b10));
        check("fwd_m_b", 32'(fwd_b_e), 32'(2'b10));
        check("fwd_ctl", 32'(ctl), 32'(C_NONE));
        wreg_m = 5'd7;
        #1;
        check("fwd_w_a", 32'(fwd_a_e), 32'(2'b01));
        check("fwd_w_b", 32'(fwd_b_e), 32'(2'b01));
        regwrite_m = 1'b1; wreg_m = 5'd0; regwrite_w = 1'b1; wreg_w = 5'd0;
        rs_e = 5'd0; rt_e = 5'd0;
        #1;
        check("fwd_r0", 32'({fwd_a_e, fwd_b_e}), 32'(4'b0000));
        regwrite_m = 1'b0; wreg_m = 5'd9; regwrite_w = 1'b0; wreg_w = 5'd9;
        rs_e = 5'd9; rt_e = 5'd9;
        #1;
        check("fwd_nowr", 32'({fwd_a_e, fwd_b_e}), 32'(4'b0000));
        regwrite_w = 1'b1; rt_e = 5'd8;
        #1;
        check("fwd_split", 32'({fwd_a_e, fwd_b_e}), 32'(4'b0100));
        clear_inputs();
        @(posedge clk); #1;

        // Load-use: lw r5 in E, consumer reads r5 in D
        memtoreg_e = 1'b1; regwrite_e = 1'b1; wreg_e = 5'd5; rs_d = 5'd5;
        cyc("lu_stall", C_LU);
        clear_inputs();
        rs_e = 5'd5; regwrite_w = 1'b1; wreg_w = 5'd5;
        #1;
        check("lu_fwd", 32'(fwd_a_e), 32'(2'b01));
        cyc("lu_after", C_NONE);
        memtoreg_e = 1'b1; regwrite_e = 1'b1; wreg_e = 5'd6; rt_d = 5'd6; rs_d = 5'd1;
        cyc("lu_rt", C_LU);
        wreg_e = 5'd0; rt_d = 5'd0;
        cyc("lu_r0", C_NONE);
        memtoreg_e = 1'b0; wreg_e = 5'd6; rt_d = 5'd6;
        cyc("lu_noload", C_NONE);
        clear_inputs();

        // Redirect alone, and redirect over load-use
        redirect_e = 1'b1;
        cyc("redir", C_RED);
        memtoreg_e = 1'b1; regwrite_e = 1'b1; wreg_e = 5'd5; rs_d = 5'd5;
        cyc("redir_over_lu", C_RED);
        clear_inputs();

        // Divide: 1 detect + 4 busy + 1 done, then back-to-back divide
        div_start_e = 1'b1;
        redirect_e = 1'b1;
        cyc("div_detect", C_DIV);
        redirect_e = 1'b0;
        for (int i = 0; i < 4; i++) cyc("div_busy", C_DIV);
        cyc("div_done", C_DONE);
        cyc("b2b_detect", C_DIV);
        for (int i = 0; i < 4; i++) cyc("b2b_busy", C_DIV);
        cyc("b2b_done", C_DONE);
        div_start_e = 1'b0;
        cyc("div_idle", C_NONE);

        // Memory stall over BUSY keeps counting; stall over DONE holds div_done
        div_start_e = 1'b1;
        cyc("ms_detect", C_DIV);
        mem_req_m = 1'b1; mem_ready_m = 1'b0;
        for (int i = 0; i < 3; i++) cyc("ms_busy", C_MEM_BUSY);
        mem_req_m = 1'b0;
        cyc("ms_last_busy", C_DIV);
        mem_req_m = 1'b1;
        cyc("ms_done_hold1", C_MEM_DONE);
        cyc("ms_done_hold2", C_MEM_DONE);
        mem_ready_m = 1'b1;
        cyc("ms_done_rel", C_DONE);
        clear_inputs();
        cyc("ms_idle", C_NONE);

        // Redirect held off by a memory stall, then acted on
        redirect_e = 1'b1; mem_req_m = 1'b1; mem_ready_m = 1'b0;
        cyc("rd_ms1", C_MEM);
        cyc("rd_ms2", C_MEM);
        mem_ready_m = 1'b1;
        cyc("rd_go", C_RED);
        clear_inputs();

        // Reset in BUSY with cnt==2 abandons the divide
        div_start_e = 1'b1;
        cyc("rb_detect", C_DIV);
        cyc("rb_busy3", C_DIV);
        rst = 1'b1;
        cyc("rb_in_rst", C_NONE);
        rst = 1'b0;
        div_start_e = 1'b0;
        for (int i = 0; i < 6; i++) cyc("rb_no_done", C_NONE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
